// File: rtl/adv7619_int_pkg.sv
// Shared constants for the ADV7619 INT1 conditioner: state encoding, register map
// and the sizing helper for the shared down-counter.
package adv7619_int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUAL    = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } int_state_e;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_EVENTS = 2'd1;
    localparam logic [1:0] ADDR_GLITCH = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    localparam int STAT_S_BIT     = 0;
    localparam int STAT_OUT_BIT   = 1;
    localparam int STAT_STATE_LSB = 2;

    // The timer only ever holds a load value of (cycles - 1) or less.
    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/adv7619_int_conditioner_int_sync.sv
// Multi-flop synchroniser for an asynchronous level; resets to a chosen idle level
// so a reset never looks like an incoming interrupt.
module int_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/adv7619_int_conditioner.sv
// ADV7619 INT1 conditioner: synchronise, glitch-filter, stretch and hold off the pin,
// producing a clean active-low level for the HDMI interrupt PIO, plus a status slave.
//
//   state   | meaning
//   IDLE    | armed, waiting for the pin to go active
//   QUAL    | pin active, counting consecutive active samples
//   ASSERT  | int_out low, held for at least MIN_LOW_CYCLES and while pin active
//   HOLDOFF | int_out high, pin ignored until the re-arm timer expires
module adv7619_int_conditioner
    import adv7619_int_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 8,
    parameter int MIN_LOW_CYCLES = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_W          = 16,
    parameter int ACTIVE_LOW     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        int_pin,
    output logic        int_out,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata
);

    localparam logic PIN_INV = (ACTIVE_LOW != 0);
    localparam int   TMR_W   = tmr_width(FILTER_CYCLES, MIN_LOW_CYCLES, HOLDOFF_CYCLES);

    // QUAL is entered having already seen one active sample; terminal count is zero.
    localparam logic [TMR_W-1:0] FILT_LOAD = TMR_W'((FILTER_CYCLES >= 2) ? FILTER_CYCLES - 2 : 0);
    localparam logic [TMR_W-1:0] MINL_LOAD = TMR_W'(MIN_LOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             pin_sync;
    logic             s;

    int_state_e       state_q,      state_d;
    logic [TMR_W-1:0] timer_q,      timer_d;
    logic             int_out_q,    int_out_d;
    logic [CNT_W-1:0] event_cnt_q,  event_cnt_d;
    logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
    logic             enable_q,     enable_d;
    logic [31:0]      readdata_q,   readdata_d;

    logic             event_inc;
    logic             glitch_inc;
    logic             ctrl_wr;
    logic             cnt_clr;
    logic             wdata_unused;

    int_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (PIN_INV)
    ) u_int_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (int_pin),
        .q       (pin_sync)
    );

    assign s = pin_sync ^ PIN_INV;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        event_inc  = 1'b0;
        glitch_inc = 1'b0;
        if (!enable_q) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s) begin
                        if (FILTER_CYCLES == 1) begin
                            state_d   = ST_ASSERT;
                            timer_d   = MINL_LOAD;
                            event_inc = 1'b1;
                        end else begin
                            state_d = ST_QUAL;
                            timer_d = FILT_LOAD;
                        end
                    end
                end
                ST_QUAL: begin
                    if (!s) begin
                        state_d    = ST_IDLE;
                        glitch_inc = 1'b1;
                    end else if (timer_q == '0) begin
                        state_d   = ST_ASSERT;
                        timer_d   = MINL_LOAD;
                        event_inc = 1'b1;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_ASSERT: begin
                    // Once the minimum low time is met, the level follows the pin.
                    if (timer_q != '0) begin
                        timer_d = timer_q - TMR_W'(1);
                    end else if (!s) begin
                        state_d = ST_HOLDOFF;
                        timer_d = HOLD_LOAD;
                    end
                end
                ST_HOLDOFF: begin
                    if (timer_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
        int_out_d = (state_d != ST_ASSERT);
    end

    always_comb begin
        ctrl_wr      = chipselect & ~write_n & (address == ADDR_CTRL);
        cnt_clr      = ctrl_wr & writedata[CTRL_CLEAR_BIT];
        enable_d     = ctrl_wr ? writedata[CTRL_ENABLE_BIT] : enable_q;
        wdata_unused = ^writedata[31:2];

        event_cnt_d = event_cnt_q;
        if (cnt_clr) begin
            event_cnt_d = '0;
        end else if (event_inc && (event_cnt_q != CNT_MAX)) begin
            event_cnt_d = event_cnt_q + CNT_W'(1);
        end

        glitch_cnt_d = glitch_cnt_q;
        if (cnt_clr) begin
            glitch_cnt_d = '0;
        end else if (glitch_inc && (glitch_cnt_q != CNT_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATUS: begin
                readdata_d[STAT_S_BIT]             = s;
                readdata_d[STAT_OUT_BIT]           = int_out_q;
                readdata_d[STAT_STATE_LSB +: 2]    = state_q;
            end
            ADDR_EVENTS: readdata_d[CNT_W-1:0]     = event_cnt_q;
            ADDR_GLITCH: readdata_d[CNT_W-1:0]     = glitch_cnt_q;
            ADDR_CTRL:   readdata_d[CTRL_ENABLE_BIT] = enable_q;
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            int_out_q    <= 1'b1;
            event_cnt_q  <= '0;
            glitch_cnt_q <= '0;
            enable_q     <= 1'b1;
            readdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            int_out_q    <= int_out_d;
            event_cnt_q  <= event_cnt_d;
            glitch_cnt_q <= glitch_cnt_d;
            enable_q     <= enable_d;
            readdata_q   <= readdata_d;
        end
    end

    assign int_out  = int_out_q;
    assign readdata = readdata_q;

endmodule
